// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage with memory handshake, stall hold buffer and wrong-path drain.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] out_PC_4,
  output logic [31:0] out_Instruction,
  output logic        Flush
);
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        redir_eff, flush_c;
  logic [31:0] tgt, pc4, instr_c, pc4_c;
  assign redir_eff = Redirect & ~Stall;
  assign tgt       = {Redirect_Target[31:2], 2'b00};
  assign pc4       = fetch_addr_q + 32'd4;
  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    redirect_pc_d = redirect_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    flush_c       = 1'b1;
    instr_c       = NOP_INSTR;
    pc4_c         = pc4;
    case (state_q)
      S_FETCH: begin
        if (redir_eff) begin
          if (IMem_Ready) fetch_addr_d = tgt;
          else begin
            redirect_pc_d = tgt;
            state_d       = S_DISCARD;
          end
        end else if (IMem_Ready) begin
          fetch_addr_d = pc4;
          if (Stall) begin
            hold_instr_d = IMem_Data;
            hold_pc4_d   = pc4;
            state_d      = S_HOLD;
          end else begin
            flush_c = 1'b0;
            instr_c = IMem_Data;
          end
        end
      end
      S_HOLD: begin
        pc4_c = hold_pc4_q;
        if (!Stall) state_d = S_FETCH;
        if (redir_eff) fetch_addr_d = tgt;
        else begin
          flush_c = 1'b0;
          instr_c = hold_instr_q;
        end
      end
      S_DISCARD: begin
        // Latest redirect wins, including one arriving with the draining response.
        if (redir_eff) redirect_pc_d = tgt;
        if (IMem_Ready) begin
          fetch_addr_d = redir_eff ? tgt : redirect_pc_q;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      fetch_addr_q  <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      hold_instr_q  <= 32'h0;
      hold_pc4_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      redirect_pc_q <= redirect_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc4_q    <= hold_pc4_d;
    end
  end
  assign IMem_Req        = reset && (state_q != S_HOLD);
  assign IMem_Addr       = fetch_addr_q;
  assign Flush           = !reset || flush_c;
  assign out_Instruction = reset ? instr_c : 32'h0;
  assign out_PC_4        = reset ? pc4_c : RESET_PC;
endmodule
